// File: rtl/cam_gen.sv
// Camera-style video source: reads a pixel frame buffer in raster order
// and replays it as a vsync/href/8-bit byte stream, high byte first.
module cam_gen #(
    parameter int H_ACT     = 320,
    parameter int V_ACT     = 240,
    parameter int H_BLANK   = 144,
    parameter int VS_LINES  = 3,
    parameter int VBP_LINES = 17,
    parameter int VFP_LINES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [16:0] addr,
    output logic        re,
    input  logic [15:0] rdata,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  d,
    output logic        frame_done
);

    localparam int L    = 2 * H_ACT + H_BLANK;
    localparam int HW   = $clog2(L);
    localparam int VM1  = (VS_LINES > VBP_LINES) ? VS_LINES : VBP_LINES;
    localparam int VM2  = (VFP_LINES > V_ACT) ? VFP_LINES : V_ACT;
    localparam int VMAX = (VM1 > VM2) ? VM1 : VM2;
    localparam int VW   = $clog2(VMAX + 1);
    localparam int NPIX = H_ACT * V_ACT;
    localparam int PW   = $clog2(NPIX + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(L - 1);
    localparam logic [HW-1:0] H_PRE    = HW'(L - 2);
    localparam logic [HW-1:0] HREF_END = HW'(2 * H_ACT);
    localparam logic [HW-1:0] RE_END   = HW'(2 * H_ACT - 2);

    localparam logic [VW-1:0] VS_LAST  = VW'(VS_LINES - 1);
    localparam logic [VW-1:0] VBP_LAST = VW'(VBP_LINES - 1);
    localparam logic [VW-1:0] ACT_LAST = VW'(V_ACT - 1);
    localparam logic [VW-1:0] VFP_LAST = VW'(VFP_LINES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBP,
        S_ACTIVE,
        S_VFP
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [VW-1:0] v_last;
    logic          line_end;
    logic [PW-1:0] pix_q, pix_d;
    logic [16:0]   addr_q, addr_d;
    logic          re_q, re_d;
    logic          rv_q;
    logic [7:0]    lo_q;
    logic [7:0]    d_q, d_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic          done_q, done_d;

    assign line_end = (h_q == H_LAST);

    always_comb begin
        v_last = VS_LAST;
        unique case (state_q)
            S_VBP:    v_last = VBP_LAST;
            S_ACTIVE: v_last = ACT_LAST;
            S_VFP:    v_last = VFP_LAST;
            default:  v_last = VS_LAST;
        endcase
    end

    // Every non-idle phase is a whole number of line periods, so one
    // h/v counter pair times all of them.
    always_comb begin
        state_d = state_q;
        h_d     = line_end ? '0 : h_q + 1'b1;
        v_d     = v_q;
        if (state_q == S_IDLE) begin
            h_d = '0;
            v_d = '0;
            if (en) state_d = S_VSYNC;
        end else if (line_end) begin
            if (v_q == v_last) begin
                v_d = '0;
                unique case (state_q)
                    S_VSYNC:  state_d = S_VBP;
                    S_VBP:    state_d = S_ACTIVE;
                    S_ACTIVE: state_d = S_VFP;
                    S_VFP:    state_d = en ? S_VSYNC : S_IDLE;
                    default:  state_d = S_IDLE;
                endcase
            end else begin
                v_d = v_q + 1'b1;
            end
        end
    end

    // Fetch runs two clocks ahead of the high byte, so the first fetch of
    // each line falls in the last two clocks of the preceding line period.
    always_comb begin
        vsync_d = (state_d == S_VSYNC);
        href_d  = (state_d == S_ACTIVE) && (h_d < HREF_END);
        done_d  = (state_d == S_VFP) && (h_d == H_LAST) && (v_d == VFP_LAST);
        re_d    = 1'b0;
        if (state_d == S_VBP)
            re_d = (v_d == VBP_LAST) && (h_d == H_PRE);
        else if (state_d == S_ACTIVE)
            re_d = (!h_d[0] && (h_d < RE_END)) ||
                   ((h_d == H_PRE) && (v_d != ACT_LAST));
    end

    always_comb begin
        pix_d  = pix_q;
        addr_d = addr_q;
        if (state_d == S_IDLE || state_d == S_VSYNC) begin
            pix_d  = '0;
            addr_d = '0;
        end else if (re_d) begin
            addr_d = 17'(pix_q);
            pix_d  = pix_q + 1'b1;
        end
    end

    always_comb begin
        d_d = 8'd0;
        if (href_d) d_d = rv_q ? rdata[15:8] : lo_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            pix_q   <= '0;
            addr_q  <= '0;
            re_q    <= 1'b0;
            rv_q    <= 1'b0;
            lo_q    <= 8'd0;
            d_q     <= 8'd0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            pix_q   <= pix_d;
            addr_q  <= addr_d;
            re_q    <= re_d;
            rv_q    <= re_q;
            if (rv_q) lo_q <= rdata[7:0];
            d_q     <= d_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            done_q  <= done_d;
        end
    end

    assign pclk       = clk;
    assign addr       = addr_q;
    assign re         = re_q;
    assign d          = d_q;
    assign vsync      = vsync_q;
    assign href       = href_q;
    assign frame_done = done_q;

endmodule
